// File: rtl/chanlink_pkg.sv
// Shared definitions for the chanlink readout arbiter and its helpers.
package chanlink_pkg;

   localparam int FRAME_W = 16;
   localparam int ID_W    = 3;

   // Frame delimiters emitted by the channel FIFOs.
   localparam logic [FRAME_W-1:0] FRAME_HDR = 16'h700C;
   localparam logic [FRAME_W-1:0] FRAME_TRL = 16'h7FFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } arbState_e;

endpackage

// File: rtl/chanlink_rd_arbiter_rr_pick.sv
// Combinational round-robin priority picker: the first eligible requester
// found after the last-served slot wins.
module rr_pick
   import chanlink_pkg::*;
#(
   parameter int N_CH = 6
)
(
   input  logic [N_CH-1:0] elig_i,
   input  logic [ID_W-1:0] ptr_i,
   output logic [N_CH-1:0] gnt_o,
   output logic [ID_W-1:0] idx_o,
   output logic            any_o
);

   // Walk upward from ptr+1, wrapping, and keep the first set bit.
   always_comb begin
      int               cand;
      logic [ID_W-1:0]  candIdx;
      gnt_o   = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      cand    = 0;
      candIdx = '0;
      for (int off = 1; off <= N_CH; off++) begin
         cand    = (int'(ptr_i) + off) % N_CH;
         candIdx = ID_W'(cand);
         if (!any_o && elig_i[candIdx]) begin
            gnt_o[candIdx] = 1'b1;
            idx_o          = candIdx;
            any_o          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/chanlink_rd_arbiter.sv
// Shares one readout link between N_CH channel FIFOs: round-robin grant held
// for a whole frame, registered data mux, idle gap and stall timeout.
module chanlink_rd_arbiter
   import chanlink_pkg::*;
#(
   parameter int N_CH    = 6,
   parameter int GAP_CYC = 2,
   parameter int TMO_CYC = 255
)
(
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    ena_i,
   input  logic [N_CH-1:0]         chMask_i,
   input  logic [N_CH-1:0]         chRdy_i,
   input  logic [N_CH-1:0]         chDvalid_i,
   input  logic [N_CH-1:0]         chLast_i,
   input  logic [FRAME_W*N_CH-1:0] chDout_i,
   output logic [N_CH-1:0]         chGnt_o,
   output logic [FRAME_W-1:0]      dout_o,
   output logic                    dvalid_o,
   output logic                    lastWrd_o,
   output logic [ID_W-1:0]         gntId_o,
   output logic                    busy_o,
   output logic                    tmoErr_o,
   output logic [7:0]              tmoCnt_o
);

   localparam logic [7:0]      TMO_LIM = 8'(TMO_CYC - 1);
   localparam logic [3:0]      GAP_LD  = 4'(GAP_CYC);
   localparam logic [ID_W-1:0] PTR_RST = ID_W'(N_CH - 1);

   arbState_e         state_q;
   logic [ID_W-1:0]   ptr_q;
   logic [N_CH-1:0]   chGnt_q;
   logic [ID_W-1:0]   gntId_q;
   logic              busy_q;
   logic [FRAME_W-1:0] dout_q;
   logic              dvalid_q;
   logic              lastWrd_q;
   logic              tmoErr_q;
   logic [7:0]        tmoCnt_q;
   logic [7:0]        tmoCnt_d;
   logic [7:0]        tmr_q;
   logic [3:0]        gapCnt_q;

   logic [N_CH-1:0]   elig;
   logic [N_CH-1:0]   pickGnt;
   logic [ID_W-1:0]   pickIdx;
   logic              pickAny;

   logic [FRAME_W-1:0] selDout;
   logic              selValid;
   logic              selLast;

   assign elig     = chRdy_i & ~chMask_i;
   assign tmoCnt_d = (tmoCnt_q == 8'hFF) ? tmoCnt_q : tmoCnt_q + 8'd1;

   rr_pick #(.N_CH(N_CH)) uPick (
      .elig_i (elig),
      .ptr_i  (ptr_q),
      .gnt_o  (pickGnt),
      .idx_o  (pickIdx),
      .any_o  (pickAny)
   );

   // Select the granted channel's stream; nothing passes once the grant drops.
   always_comb begin
      selDout  = '0;
      selValid = 1'b0;
      selLast  = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (chGnt_q[i]) begin
            selDout  = chDout_i[i*FRAME_W +: FRAME_W];
            selValid = chDvalid_i[i];
            selLast  = chLast_i[i];
         end
      end
   end

   // Arbitration FSM with all link outputs registered in the same block.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         ptr_q     <= PTR_RST;
         chGnt_q   <= '0;
         gntId_q   <= '0;
         busy_q    <= 1'b0;
         dout_q    <= '0;
         dvalid_q  <= 1'b0;
         lastWrd_q <= 1'b0;
         tmoErr_q  <= 1'b0;
         tmoCnt_q  <= '0;
         tmr_q     <= '0;
         gapCnt_q  <= '0;
      end else begin
         tmoErr_q  <= 1'b0;
         dout_q    <= '0;
         dvalid_q  <= 1'b0;
         lastWrd_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (ena_i && pickAny) begin
                  chGnt_q <= pickGnt;
                  gntId_q <= pickIdx;
                  ptr_q   <= pickIdx;
                  busy_q  <= 1'b1;
                  tmr_q   <= '0;
                  state_q <= GRANT;
               end
            end
            GRANT: begin
               dout_q    <= selDout;
               dvalid_q  <= selValid;
               lastWrd_q <= selLast & selValid;
               if (selValid) begin
                  tmr_q <= '0;
                  if (selLast) begin
                     chGnt_q  <= '0;
                     gapCnt_q <= GAP_LD;
                     state_q  <= GAP;
                  end
               end else if (tmr_q == TMO_LIM) begin
                  chGnt_q  <= '0;
                  dvalid_q <= 1'b0;
                  tmoErr_q <= 1'b1;
                  tmoCnt_q <= tmoCnt_d;
                  gapCnt_q <= GAP_LD;
                  state_q  <= GAP;
               end else begin
                  tmr_q <= tmr_q + 8'd1;
               end
            end
            GAP: begin
               if (gapCnt_q == 4'd0) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  gapCnt_q <= gapCnt_q - 4'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign chGnt_o   = chGnt_q;
   assign dout_o    = dout_q;
   assign dvalid_o  = dvalid_q;
   assign lastWrd_o = lastWrd_q;
   assign gntId_o   = gntId_q;
   assign busy_o    = busy_q;
   assign tmoErr_o  = tmoErr_q;
   assign tmoCnt_o  = tmoCnt_q;

endmodule
